// File: rtl/ddr_seq_pkg.sv
// Shared encodings for the DDR application sequencer.
// MIG command codes, UI widths and sequencer states.
package ddr_seq_pkg;

  localparam int unsigned UI_ADDR_W = 28;
  localparam int unsigned UI_DATA_W = 128;
  localparam int unsigned UI_MASK_W = UI_DATA_W / 8;

  localparam logic [2:0] MIG_CMD_WRITE = 3'b000;
  localparam logic [2:0] MIG_CMD_READ  = 3'b001;

  typedef enum logic [2:0] {
    S_CALIB   = 3'd0,
    S_IDLE    = 3'd1,
    S_WR      = 3'd2,
    S_RD_CMD  = 3'd3,
    S_RD_WAIT = 3'd4,
    S_RESP    = 3'd5
  } seq_state_t;

endpackage

// File: rtl/ddr_seq_watchdog.sv
// Read-wait watchdog: counts cycles while i_run is high.
// o_expired flags the cycle on which the count reaches the limit.
module ddr_seq_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic i_rst,
  input  logic i_run,
  output logic o_expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  // Held at zero outside the wait so every wait starts fresh.
  always_ff @(posedge clk) begin
    if (i_rst || !i_run) begin
      r_cnt <= '0;
    end else if (r_cnt != CW'(TIMEOUT_CYCLES)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_expired = i_run && (r_cnt == LAST);

endmodule

// File: rtl/ddr_app_sequencer.sv
// Single-outstanding MCU arbiter to MIG UI command sequencer.
// Optional read watchdog enabled by DDR_SEQ_TIMEOUT_EN.
module ddr_app_sequencer
  import ddr_seq_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = UI_ADDR_W,
  parameter int unsigned DATA_WIDTH     = UI_DATA_W,
  parameter int unsigned MASK_WIDTH     = UI_MASK_W,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk_166M66,
  input  logic                  mcu_sys_rst,
  input  logic                  i_init_calib_complete,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_rw,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  input  logic [MASK_WIDTH-1:0] i_req_wbe,
  output logic                  o_rsp_valid,
  output logic                  o_rsp_rw,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                  o_rsp_err,
  output logic [ADDR_WIDTH-1:0] o_app_addr,
  output logic [2:0]            o_app_cmd,
  output logic                  o_app_en,
  input  logic                  i_app_rdy,
  output logic [DATA_WIDTH-1:0] o_app_wdf_data,
  output logic [MASK_WIDTH-1:0] o_app_wdf_mask,
  output logic                  o_app_wdf_wren,
  output logic                  o_app_wdf_end,
  input  logic                  i_app_wdf_rdy,
  input  logic [DATA_WIDTH-1:0] i_app_rd_data,
  input  logic                  i_app_rd_data_valid,
  input  logic                  i_app_rd_data_end
);

  seq_state_t r_state, w_state_nxt;

  logic                  r_req_ready, w_req_ready_nxt;
  logic                  r_rw, w_rw_nxt;
  logic                  r_cmd_done, w_cmd_done_nxt;
  logic                  r_dat_done, w_dat_done_nxt;
  logic                  r_app_en, w_app_en_nxt;
  logic                  r_wren, w_wren_nxt;
  logic [2:0]            r_app_cmd, w_app_cmd_nxt;
  logic [ADDR_WIDTH-1:0] r_app_addr, w_app_addr_nxt;
  logic [DATA_WIDTH-1:0] r_wdata, w_wdata_nxt;
  logic [MASK_WIDTH-1:0] r_wmask, w_wmask_nxt;
  logic                  r_rsp_valid, w_rsp_valid_nxt;
  logic                  r_rsp_rw, w_rsp_rw_nxt;
  logic [DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic                  r_rsp_err, w_rsp_err_nxt;

  logic w_accept;
  logic w_cmd_hs;
  logic w_dat_hs;
  logic w_wd_expired;
  logic w_unused;

  // The beat-end flag is not checked: a single beat per read.
  assign w_unused = i_app_rd_data_end;

`ifdef DDR_SEQ_TIMEOUT_EN
  ddr_seq_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk_166M66),
    .i_rst     (mcu_sys_rst),
    .i_run     (r_state == S_RD_WAIT),
    .o_expired (w_wd_expired)
  );
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES == 0);
  assign w_wd_expired = 1'b0;
`endif

  assign w_accept = (r_state == S_IDLE) && i_req_valid && r_req_ready;
  assign w_cmd_hs = r_app_en && i_app_rdy;
  assign w_dat_hs = r_wren && i_app_wdf_rdy;

  always_comb begin
    w_state_nxt     = r_state;
    w_rw_nxt        = r_rw;
    w_cmd_done_nxt  = r_cmd_done;
    w_dat_done_nxt  = r_dat_done;
    w_app_en_nxt    = r_app_en;
    w_wren_nxt      = r_wren;
    w_app_cmd_nxt   = r_app_cmd;
    w_app_addr_nxt  = r_app_addr;
    w_wdata_nxt     = r_wdata;
    w_wmask_nxt     = r_wmask;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_rw_nxt    = 1'b0;
    w_rsp_rdata_nxt = '0;
    w_rsp_err_nxt   = 1'b0;

    unique case (r_state)
      S_CALIB: begin
        if (i_init_calib_complete) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_IDLE: begin
        if (w_accept) begin
          w_rw_nxt       = i_req_rw;
          w_app_addr_nxt = i_req_addr;
          w_wdata_nxt    = i_req_wdata;
          w_wmask_nxt    = ~i_req_wbe;
          w_app_en_nxt   = 1'b1;
          w_cmd_done_nxt = 1'b0;
          w_dat_done_nxt = 1'b0;
          if (i_req_rw) begin
            w_state_nxt   = S_WR;
            w_app_cmd_nxt = MIG_CMD_WRITE;
            w_wren_nxt    = 1'b1;
          end else begin
            w_state_nxt   = S_RD_CMD;
            w_app_cmd_nxt = MIG_CMD_READ;
          end
        end else if (!i_init_calib_complete) begin
          w_state_nxt = S_CALIB;
        end
      end
      S_WR: begin
        if (w_cmd_hs) begin
          w_app_en_nxt   = 1'b0;
          w_cmd_done_nxt = 1'b1;
        end
        if (w_dat_hs) begin
          w_wren_nxt     = 1'b0;
          w_dat_done_nxt = 1'b1;
        end
        if ((r_cmd_done || w_cmd_hs) && (r_dat_done || w_dat_hs)) begin
          w_state_nxt     = S_RESP;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_rw_nxt    = r_rw;
        end
      end
      S_RD_CMD: begin
        if (w_cmd_hs) begin
          w_app_en_nxt = 1'b0;
          w_state_nxt  = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        // A beat landing on the expiry cycle still wins.
        if (i_app_rd_data_valid) begin
          w_state_nxt     = S_RESP;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_rw_nxt    = r_rw;
          w_rsp_rdata_nxt = i_app_rd_data;
        end else if (w_wd_expired) begin
          w_state_nxt     = S_RESP;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_rw_nxt    = r_rw;
          w_rsp_err_nxt   = 1'b1;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt  = S_CALIB;
        w_app_en_nxt = 1'b0;
        w_wren_nxt   = 1'b0;
      end
    endcase

    w_req_ready_nxt = (w_state_nxt == S_IDLE) && i_init_calib_complete;
  end

  always_ff @(posedge clk_166M66) begin
    if (mcu_sys_rst) begin
      r_state     <= S_CALIB;
      r_req_ready <= 1'b0;
      r_rw        <= 1'b0;
      r_cmd_done  <= 1'b0;
      r_dat_done  <= 1'b0;
      r_app_en    <= 1'b0;
      r_wren      <= 1'b0;
      r_app_cmd   <= '0;
      r_app_addr  <= '0;
      r_wdata     <= '0;
      r_wmask     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rw    <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_rw        <= w_rw_nxt;
      r_cmd_done  <= w_cmd_done_nxt;
      r_dat_done  <= w_dat_done_nxt;
      r_app_en    <= w_app_en_nxt;
      r_wren      <= w_wren_nxt;
      r_app_cmd   <= w_app_cmd_nxt;
      r_app_addr  <= w_app_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_wmask     <= w_wmask_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rw    <= w_rsp_rw_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
    end
  end

  assign o_req_ready    = r_req_ready;
  assign o_rsp_valid    = r_rsp_valid;
  assign o_rsp_rw       = r_rsp_rw;
  assign o_rsp_rdata    = r_rsp_rdata;
  assign o_rsp_err      = r_rsp_err;
  assign o_app_addr     = r_app_addr;
  assign o_app_cmd      = r_app_cmd;
  assign o_app_en       = r_app_en;
  assign o_app_wdf_data = r_wdata;
  assign o_app_wdf_mask = r_wmask;
  assign o_app_wdf_wren = r_wren;
  assign o_app_wdf_end  = r_wren;

endmodule

// File: tb/tb_ddr_app_sequencer.sv
// Directed self-checking bench for ddr_app_sequencer.
// The timeout scenario runs only with DDR_SEQ_TIMEOUT_EN defined.
module tb_ddr_app_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic         calib;
  logic         req_valid;
  logic         req_ready;
  logic         req_rw;
  logic [27:0]  req_addr;
  logic [127:0] req_wdata;
  logic [15:0]  req_wbe;
  logic         rsp_valid;
  logic         rsp_rw;
  logic [127:0] rsp_rdata;
  logic         rsp_err;
  logic [27:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en;
  logic         app_rdy;
  logic [127:0] wdf_data;
  logic [15:0]  wdf_mask;
  logic         wdf_wren;
  logic         wdf_end;
  logic         wdf_rdy;
  logic [127:0] rd_data;
  logic         rd_valid;
  logic         rd_end;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] WD_A5 = {16{8'hA5}};
  localparam logic [127:0] WD_5A = {16{8'h5A}};
  localparam logic [127:0] RD_12 = {8{16'h1234}};
  localparam logic [127:0] RD_EE = {8{16'hDEAD}};

  always #3 clk = ~clk;

  ddr_app_sequencer #(
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk_166M66            (clk),
    .mcu_sys_rst           (rst),
    .i_init_calib_complete (calib),
    .i_req_valid           (req_valid),
    .o_req_ready           (req_ready),
    .i_req_rw              (req_rw),
    .i_req_addr            (req_addr),
    .i_req_wdata           (req_wdata),
    .i_req_wbe             (req_wbe),
    .o_rsp_valid           (rsp_valid),
    .o_rsp_rw              (rsp_rw),
    .o_rsp_rdata           (rsp_rdata),
    .o_rsp_err             (rsp_err),
    .o_app_addr            (app_addr),
    .o_app_cmd             (app_cmd),
    .o_app_en              (app_en),
    .i_app_rdy             (app_rdy),
    .o_app_wdf_data        (wdf_data),
    .o_app_wdf_mask        (wdf_mask),
    .o_app_wdf_wren        (wdf_wren),
    .o_app_wdf_end         (wdf_end),
    .i_app_wdf_rdy         (wdf_rdy),
    .i_app_rd_data         (rd_data),
    .i_app_rd_data_valid   (rd_valid),
    .i_app_rd_data_end     (rd_end)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic rw,
                     input logic [27:0] a,
                     input logic [127:0] d,
                     input logic [15:0] be);
    req_valid = 1'b1;
    req_rw    = rw;
    req_addr  = a;
    req_wdata = d;
    req_wbe   = be;
  endtask

  initial begin
    rst       = 1'b1;
    calib     = 1'b0;
    req_valid = 1'b0;
    req_rw    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_wbe   = '0;
    app_rdy   = 1'b0;
    wdf_rdy   = 1'b0;
    rd_data   = '0;
    rd_valid  = 1'b0;
    rd_end    = 1'b0;

    // 1: reset state, then calibration
    repeat (3) step();
    chk("rst_ready", 128'(req_ready), 128'(0));
    chk("rst_en", 128'(app_en), 128'(0));
    chk("rst_wren", 128'(wdf_wren), 128'(0));
    chk("rst_end", 128'(wdf_end), 128'(0));
    chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("rst_rsp_err", 128'(rsp_err), 128'(0));
    chk("rst_addr", 128'(app_addr), 128'(0));
    chk("rst_mask", 128'(wdf_mask), 128'(0));
    rst = 1'b0;
    step();
    chk("calib0_ready", 128'(req_ready), 128'(0));
    calib = 1'b1;
    step();
    chk("calib1_ready", 128'(req_ready), 128'(1));

    // 2: write, both channels ready immediately
    app_rdy = 1'b1;
    wdf_rdy = 1'b1;
    req(1'b1, 28'h0000100, WD_A5, 16'h00FF);
    step();
    req_valid = 1'b0;
    chk("w2_en", 128'(app_en), 128'(1));
    chk("w2_wren", 128'(wdf_wren), 128'(1));
    chk("w2_end", 128'(wdf_end), 128'(1));
    chk("w2_cmd", 128'(app_cmd), 128'(0));
    chk("w2_addr", 128'(app_addr), 128'(28'h0000100));
    chk("w2_mask", 128'(wdf_mask), 128'(16'hFF00));
    chk("w2_data", wdf_data, WD_A5);
    chk("w2_ready_busy", 128'(req_ready), 128'(0));
    step();
    chk("w2_en_drop", 128'(app_en), 128'(0));
    chk("w2_wren_drop", 128'(wdf_wren), 128'(0));
    chk("w2_rsp_valid", 128'(rsp_valid), 128'(1));
    chk("w2_rsp_rw", 128'(rsp_rw), 128'(1));
    chk("w2_rsp_rdata", rsp_rdata, 128'(0));
    chk("w2_rsp_err", 128'(rsp_err), 128'(0));
    step();
    chk("w2_rsp_pulse", 128'(rsp_valid), 128'(0));
    chk("w2_ready_back", 128'(req_ready), 128'(1));

    // 3: write with write-FIFO ready delayed 5 cycles
    wdf_rdy = 1'b0;
    req(1'b1, 28'h0000200, WD_5A, 16'hFFFF);
    step();
    req_valid = 1'b0;
    chk("w3_en_c1", 128'(app_en), 128'(1));
    chk("w3_wren_c1", 128'(wdf_wren), 128'(1));
    chk("w3_mask", 128'(wdf_mask), 128'(0));
    step();
    chk("w3_en_c2", 128'(app_en), 128'(0));
    for (int i = 2; i <= 5; i++) begin
      chk("w3_wren_hold", 128'(wdf_wren), 128'(1));
      chk("w3_data_hold", wdf_data, WD_5A);
      chk("w3_no_rsp", 128'(rsp_valid), 128'(0));
      step();
    end
    wdf_rdy = 1'b1;
    chk("w3_wren_c6", 128'(wdf_wren), 128'(1));
    step();
    wdf_rdy = 1'b0;
    chk("w3_wren_drop", 128'(wdf_wren), 128'(0));
    chk("w3_rsp_valid", 128'(rsp_valid), 128'(1));
    step();
    chk("w3_rsp_pulse", 128'(rsp_valid), 128'(0));

    // 4: read, command accepted on 4th cycle, data after 20 cycles
    app_rdy = 1'b0;
    req(1'b0, 28'h0ABCDE0, '0, 16'hFFFF);
    step();
    req_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      chk("r4_en_hold", 128'(app_en), 128'(1));
      chk("r4_cmd_hold", 128'(app_cmd), 128'(1));
      step();
    end
    app_rdy = 1'b1;
    chk("r4_en_c4", 128'(app_en), 128'(1));
    chk("r4_addr", 128'(app_addr), 128'(28'h0ABCDE0));
    step();
    chk("r4_en_drop", 128'(app_en), 128'(0));
    repeat (19) begin
      chk("r4_wait_no_rsp", 128'(rsp_valid), 128'(0));
      step();
    end
    rd_valid = 1'b1;
    rd_end   = 1'b1;
    rd_data  = RD_12;
    step();
    rd_valid = 1'b0;
    rd_end   = 1'b0;
    rd_data  = RD_EE;
    chk("r4_rsp_valid", 128'(rsp_valid), 128'(1));
    chk("r4_rsp_rw", 128'(rsp_rw), 128'(0));
    chk("r4_rsp_rdata", rsp_rdata, RD_12);
    chk("r4_rsp_err", 128'(rsp_err), 128'(0));
    step();
    chk("r4_rsp_pulse", 128'(rsp_valid), 128'(0));

    // stray read beat while idle is ignored
    rd_valid = 1'b1;
    step();
    rd_valid = 1'b0;
    chk("idle_stray_rsp", 128'(rsp_valid), 128'(0));
    chk("idle_stray_ready", 128'(req_ready), 128'(1));

    // 5: reset while waiting for read data
    req(1'b0, 28'h0000300, '0, 16'hFFFF);
    step();
    req_valid = 1'b0;
    chk("r5_en", 128'(app_en), 128'(1));
    step();
    step();
    rst = 1'b1;
    step();
    chk("r5_rst_ready", 128'(req_ready), 128'(0));
    chk("r5_rst_en", 128'(app_en), 128'(0));
    chk("r5_rst_rsp", 128'(rsp_valid), 128'(0));
    chk("r5_rst_addr", 128'(app_addr), 128'(0));
    rst      = 1'b0;
    rd_valid = 1'b1;
    rd_data  = RD_EE;
    step();
    rd_valid = 1'b0;
    chk("r5_stray_rsp", 128'(rsp_valid), 128'(0));
    chk("r5_ready_again", 128'(req_ready), 128'(1));
    step();
    chk("r5_stray_rsp2", 128'(rsp_valid), 128'(0));

    // calibration loss in idle returns to calibration wait
    calib = 1'b0;
    step();
    chk("cal_drop_ready", 128'(req_ready), 128'(0));
    req(1'b1, 28'h0000400, WD_A5, 16'hFFFF);
    step();
    chk("cal_drop_no_en", 128'(app_en), 128'(0));
    req_valid = 1'b0;
    calib     = 1'b1;
    step();
    chk("cal_back_ready", 128'(req_ready), 128'(1));

`ifdef DDR_SEQ_TIMEOUT_EN
    // 6: read never answered, watchdog expires
    app_rdy = 1'b1;
    req(1'b0, 28'h0000500, '0, 16'hFFFF);
    step();
    req_valid = 1'b0;
    chk("t6_en", 128'(app_en), 128'(1));
    step();
    for (int i = 0; i < 16; i++) begin
      chk("t6_wait_no_rsp", 128'(rsp_valid), 128'(0));
      step();
    end
    chk("t6_rsp_valid", 128'(rsp_valid), 128'(1));
    chk("t6_rsp_err", 128'(rsp_err), 128'(1));
    chk("t6_rsp_rdata", rsp_rdata, 128'(0));
    rd_valid = 1'b1;
    rd_data  = RD_12;
    step();
    rd_valid = 1'b0;
    chk("t6_late_rsp", 128'(rsp_valid), 128'(0));
    chk("t6_late_err", 128'(rsp_err), 128'(0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
